muldiv_sequencer: RTL

Multi-cycle controller for the 16-bit multiply/divide resource beside the single-cycle datapath. It accepts a mult/div request from the decode stage and runs an iterative shift-add multiply or restoring divide, one bit per cycle. While it runs it holds instruction fetch via `instr_stall_sl`, then writes the HI/LO pair and pulses `ready`. `mfhi`/`mflo` reads go through `hi_lo_sl`.

---
 rtl/muldiv_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative 16-bit shift-add multiply / restoring divide sequencer
module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_lo_sl,
    output logic [WIDTH-1:0] result,
    output logic             instr_stall_sl,
    output logic             ready,
    output logic             div_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             op_q;
    logic [WIDTH-1:0] operand_q;
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_step;
    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   upper_sum;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             running;
    logic             last_step;

    assign last_step = (count == CW'(WIDTH - 1));

    // One algorithm step on the current accumulator; the final step feeds HI/LO directly.
    always_comb begin
        acc_step  = acc;
        shifted   = '0;
        upper_sum = '0;
        if (!op_q) begin
            upper_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand_q} : '0);
            acc_step  = {upper_sum, acc[WIDTH-1:0]} >> 1;
        end else begin
            shifted = acc << 1;
            if (shifted[2*WIDTH:WIDTH] >= {1'b0, operand_q}) begin
                acc_step = {shifted[2*WIDTH:WIDTH] - {1'b0, operand_q},
                            shifted[WIDTH-1:1], 1'b1};
            end else begin
                acc_step = shifted;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            op_q      <= 1'b0;
            operand_q <= '0;
            acc       <= '0;
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
            ready     <= 1'b0;
            running   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        count     <= '0;
                        op_q      <= op;
                        operand_q <= operand_b;
                        acc       <= {{(WIDTH + 1){1'b0}}, operand_a};
                        div_zero  <= 1'b0;
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + CW'(1);
                    if (last_step) begin
                        state    <= DONE;
                        running  <= 1'b0;
                        ready    <= 1'b1;
                        hi       <= acc_step[2*WIDTH-1:WIDTH];
                        lo       <= acc_step[WIDTH-1:0];
                        div_zero <= op_q && (operand_q == '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready   <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Accept-cycle term is combinational so the PC never advances past the request.
    assign instr_stall_sl = running | ((state == IDLE) & start);
    assign result         = hi_lo_sl ? hi : lo;
endmodule
